// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: MSB-first serial pattern transmitter with repeat count
// and idle gap cycles between frames. Outputs decode from registered state.
// Optional build macro SPG_PARITY_EN appends an even-parity bit to every frame.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; pattern and repeat count captured on start
// S_SHIFT | driving pattern (or parity) bits on sout
// S_GAP   | idle cycles between consecutive frames
// S_DONE  | one-cycle done pulse, then back to idle
module serial_pattern_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_SHIFT = 4'b0010,
        S_GAP   = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    localparam int BI_W  = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BI_W-1:0]  BIT_LOAD = BI_W'(PAT_W - 1);
    // Gap counter counts down to zero, so it is loaded with GAP-1.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   shift_q, shift_d;
    logic [PAT_W-1:0]   pat_hold_q, pat_hold_d;
    logic [CNT_W-1:0]   rep_left_q, rep_left_d;
    logic [BI_W-1:0]    bit_idx_q, bit_idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               frame_end;
`ifdef SPG_PARITY_EN
    logic               par_q, par_d;
`endif

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            pat_hold_q <= '0;
            rep_left_q <= '0;
            bit_idx_q  <= '0;
            gap_q      <= '0;
`ifdef SPG_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            pat_hold_q <= pat_hold_d;
            rep_left_q <= rep_left_d;
            bit_idx_q  <= bit_idx_d;
            gap_q      <= gap_d;
`ifdef SPG_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        pat_hold_d = pat_hold_q;
        rep_left_d = rep_left_q;
        bit_idx_d  = bit_idx_q;
        gap_d      = gap_q;
        frame_end  = 1'b0;
`ifdef SPG_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_hold_d = pattern;
                    shift_d    = pattern;
                    rep_left_d = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
                    bit_idx_d  = BIT_LOAD;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_d   = shift_q << 1;
                bit_idx_d = bit_idx_q - 1'b1;
`ifdef SPG_PARITY_EN
                // Last pattern bit is followed by one parity cycle.
                if (par_q) begin
                    par_d     = 1'b0;
                    frame_end = 1'b1;
                end else if (bit_idx_q == '0) begin
                    par_d     = 1'b1;
                    bit_idx_d = bit_idx_q;
                end
`else
                if (bit_idx_q == '0) frame_end = 1'b1;
`endif
                if (frame_end) begin
                    bit_idx_d = BIT_LOAD;
                    shift_d   = pat_hold_q;
                    if (rep_left_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        rep_left_d = rep_left_q - 1'b1;
                        if (GAP > 0) begin
                            state_d = S_GAP;
                            gap_d   = GAP_LOAD;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_SHIFT;
                else             gap_d   = gap_q - 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        sout_valid = (state_q == S_SHIFT);
        busy       = (state_q == S_SHIFT) || (state_q == S_GAP);
        done       = (state_q == S_DONE);
`ifdef SPG_PARITY_EN
        sout       = sout_valid && (par_q ? (^pat_hold_q) : shift_q[PAT_W-1]);
`else
        sout       = sout_valid && shift_q[PAT_W-1];
`endif
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen: two instances (GAP=1 and GAP=0),
// captured output streams compared against hand-computed bit strings.
module tb_serial_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start0;
    logic [3:0] pattern, repeat_cnt;
    logic       sout, sout_valid, busy, done;
    logic       sout0, sout_valid0, busy0, done0;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] s, v, b, d;

    always #5 clk = ~clk;

    serial_pattern_gen #(.PAT_W(4), .CNT_W(4), .GAP(1)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .repeat_cnt(repeat_cnt), .sout(sout), .sout_valid(sout_valid),
        .busy(busy), .done(done)
    );

    serial_pattern_gen #(.PAT_W(4), .CNT_W(4), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .pattern(pattern),
        .repeat_cnt(repeat_cnt), .sout(sout0), .sout_valid(sout_valid0),
        .busy(busy0), .done(done0)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Pulse start (or hold it) so it is seen by exactly one rising edge.
    task automatic send(input bit sel0, input logic [3:0] pat, input logic [3:0] rc, input bit hold);
        @(negedge clk);
        pattern    = pat;
        repeat_cnt = rc;
        if (sel0) start0 = 1'b1;
        else      start  = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            start  = 1'b0;
            start0 = 1'b0;
        end
    endtask

    // Record n cycles of outputs, first cycle first (MSB side).
    task automatic capture(input bit sel0, input int n, input int pk_on, input int pk_off,
                           output logic [31:0] so, output logic [31:0] vo,
                           output logic [31:0] bo, output logic [31:0] dn);
        so = '0; vo = '0; bo = '0; dn = '0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            so = {so[30:0], sel0 ? sout0       : sout};
            vo = {vo[30:0], sel0 ? sout_valid0 : sout_valid};
            bo = {bo[30:0], sel0 ? busy0       : busy};
            dn = {dn[30:0], sel0 ? done0       : done};
            if (i == pk_on) begin
                start      = 1'b1;
                pattern    = 4'b0011;
                repeat_cnt = 4'd7;
            end
            if (i == pk_off) start = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start0 = 1'b0;
        pattern = 4'b0000; repeat_cnt = 4'd0;
        #12;
        chk("rst_outputs", {28'd0, sout, sout_valid, busy, done}, 32'd0);
        chk("rst_outputs0", {28'd0, sout0, sout_valid0, busy0, done0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifdef SPG_PARITY_EN
        // 1101 + parity 1, back-to-back, two frames
        send(1'b1, 4'b1101, 4'd2, 1'b0);
        capture(1'b1, 12, 0, 0, s, v, b, d);
        chk("par_g0_sout",  s, 32'hDEC);
        chk("par_g0_valid", v, 32'hFFC);
        chk("par_g0_busy",  b, 32'hFFC);
        chk("par_g0_done",  d, 32'h002);
        chk("par_g0_bcnt",  $countones(b), 32'd10);

        // single frame with parity, GAP=1 instance
        send(1'b0, 4'b1101, 4'd1, 1'b0);
        capture(1'b0, 7, 0, 0, s, v, b, d);
        chk("par_g1_sout",  s, 32'h6C);
        chk("par_g1_valid", v, 32'h7C);
        chk("par_g1_busy",  b, 32'h7C);
        chk("par_g1_done",  d, 32'h02);
`else
        // single frame
        send(1'b0, 4'b1101, 4'd1, 1'b0);
        capture(1'b0, 6, 0, 0, s, v, b, d);
        chk("r1_sout",  s, 32'h34);
        chk("r1_valid", v, 32'h3C);
        chk("r1_busy",  b, 32'h3C);
        chk("r1_done",  d, 32'h02);

        // three frames with one gap cycle
        send(1'b0, 4'b1101, 4'd3, 1'b0);
        capture(1'b0, 16, 0, 0, s, v, b, d);
        chk("r3_sout",  s, 32'hD6B4);
        chk("r3_valid", v, 32'hF7BC);
        chk("r3_busy",  b, 32'hFFFC);
        chk("r3_done",  d, 32'h0002);
        chk("r3_bcnt",  $countones(b), 32'd14);

        // repeat_cnt = 0 acts as 1
        send(1'b0, 4'b1101, 4'd0, 1'b0);
        capture(1'b0, 6, 0, 0, s, v, b, d);
        chk("r0_sout",  s, 32'h34);
        chk("r0_busy",  b, 32'h3C);
        chk("r0_done",  d, 32'h02);

        // start held high: second frame accepted from the idle cycle after done
        send(1'b0, 4'b1101, 4'd1, 1'b1);
        capture(1'b0, 11, 0, 11, s, v, b, d);
        chk("hold_sout",  s, 32'h69A);
        chk("hold_valid", v, 32'h79E);
        chk("hold_done",  d, 32'h041);
        repeat (3) @(negedge clk);

        // start + new pattern mid-transmission are ignored
        send(1'b0, 4'b1101, 4'd2, 1'b0);
        capture(1'b0, 11, 2, 10, s, v, b, d);
        chk("ign_sout",  s, 32'h6B4);
        chk("ign_valid", v, 32'h7BC);
        chk("ign_busy",  b, 32'h7FC);
        chk("ign_done",  d, 32'h002);
        repeat (2) @(negedge clk);
        chk("ign_idle", {30'd0, busy, done}, 32'd0);

        // back-to-back frames on the GAP=0 instance
        send(1'b1, 4'b1101, 4'd2, 1'b0);
        capture(1'b1, 10, 0, 0, s, v, b, d);
        chk("g0_sout",  s, 32'h374);
        chk("g0_valid", v, 32'h3FC);
        chk("g0_done",  d, 32'h002);

        // reset during second bit of frame 2
        send(1'b0, 4'b1101, 4'd3, 1'b0);
        capture(1'b0, 7, 0, 0, s, v, b, d);
        chk("rmid_sout", s, 32'h6B);
        rst = 1'b1;
        #1;
        chk("rmid_async", {28'd0, sout, sout_valid, busy, done}, 32'd0);
        capture(1'b0, 4, 0, 0, s, v, b, d);
        chk("rmid_quiet", b | d | v, 32'd0);
        rst = 1'b0;
        capture(1'b0, 3, 0, 0, s, v, b, d);
        chk("rmid_nodone", b | d, 32'd0);
        send(1'b0, 4'b1101, 4'd1, 1'b0);
        capture(1'b0, 6, 0, 0, s, v, b, d);
        chk("post_rst_sout", s, 32'h34);
        chk("post_rst_done", d, 32'h02);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
Serial bit-pattern transmitter. It captures a PAT_W-bit pattern and a repeat count on start, then shifts the pattern out MSB-first on a single serial line, repeating it the requested number of times with idle gap cycles between frames. It is the stimulus and transmit side for the team's serial sequence detectors (default pattern 1101). Outputs are Moore-style: they decode from registered state only, with no combinational path from inputs to outputs.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
CNT_W, 4, width of repeat count
GAP, 1, idle cycles inserted between consecutive frames (0 allowed = back-to-back)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request transmission; sampled only in IDLE
pattern  input  PAT_W  pattern to send, captured on accepted start
repeat_cnt  input  CNT_W  number of frames; 0 treated as 1
sout  output  1  serial data; 0 when not valid
sout_valid  output  1  high while sout carries a pattern (or parity) bit
busy  output  1  high in SHIFT and GAP
done  output  1  single-cycle pulse after the last bit of the last frame

Behaviour:
- Reset is asynchronous and active-high; clock is clk. Under reset: state=IDLE, shift register=0, counters=0, sout=0, sout_valid=0, busy=0, done=0.
- States: IDLE, SHIFT, GAP, DONE. Encoding is one-hot.
- IDLE -> SHIFT on a clock edge where start=1.
  - Capture pattern into pat_hold and into the shift register.
  - Set rep_left = (repeat_cnt==0) ? 1 : repeat_cnt.
  - Set bit_idx = PAT_W-1.
- SHIFT: sout = shift_reg[MSB], sout_valid=1, busy=1.
  - Each cycle: shift left by 1 and decrement bit_idx.
  - On the last bit (bit_idx==0):
    - If rep_left==1 -> DONE.
    - Else decrement rep_left, reload the shift register from pat_hold, and go to GAP (GAP>0) or directly to SHIFT (GAP==0).
- GAP: sout=0, sout_valid=0, busy=1. Stay for exactly GAP cycles, then -> SHIFT with bit_idx=PAT_W-1.
- DONE: done=1, busy=0, sout=0, sout_valid=0 for one cycle -> IDLE unconditionally.
- Latency: start accepted at edge k gives first bit valid in the cycle after edge k.
- Busy duration: PAT_W*R + GAP*(R-1) cycles, where R is the effective repeat count. done follows in the next cycle.
- start is ignored in SHIFT, GAP and DONE. A new start in the cycle after DONE (i.e. in IDLE) is accepted.
- pattern and repeat_cnt changes after capture have no effect on a transmission in progress.
- Reset asserted mid-frame: all outputs drop to 0 immediately (asynchronously). The transmission is abandoned and done is not issued.
- Unreachable state codes recover to IDLE on the next edge.

Optional Feature:
SPG_PARITY_EN
- Defined:
  - After the PAT_W pattern bits of each frame, one extra SHIFT cycle outputs the even-parity bit (XOR of pat_hold) with sout_valid=1.
  - Frame length becomes PAT_W+1.
  - Busy duration becomes (PAT_W+1)*R + GAP*(R-1).
- Undefined: no parity bit; frame length is PAT_W. No parity logic is present.

Test Plan:
- Default parameters, pattern=4'b1101, repeat_cnt=1, start pulse -> sout_valid high 4 cycles with sout=1,1,0,1; done pulses in the 5th cycle; busy high exactly 4 cycles.
- pattern=1101, repeat_cnt=3, GAP=1 -> sout stream 1101 0 1101 0 1101 with sout_valid low only in the gap cycles; busy 14 cycles; single done pulse.
- repeat_cnt=0 -> behaves identically to repeat_cnt=1. Separately, start held high continuously -> the next transmission begins in the cycle after done.
- start and a new pattern=4'b0011 applied in the middle of a transmission -> ignored; the current 1101 frame completes unchanged.
- rst asserted during the 2nd bit of frame 2 -> sout, sout_valid and busy are 0 immediately, no done pulse; a fresh start after rst release transmits normally.
- SPG_PARITY_EN defined, pattern=1101, repeat_cnt=2, GAP=0 -> sout = 1,1,0,1,1,1,1,0,1,1 (parity bit 1 after each frame); busy 10 cycles.
